// File: rtl/ch_unit_pkg.sv
// Definitions shared by the playback and record channel units.
// The channel FSM states and the default serial word width live here.
package ch_unit_pkg;

  localparam int WORD_W_DEFAULT = 32;
  localparam int BIT_IDX_W      = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } chState_t;

endpackage

// File: rtl/playback_unit_if.sv
// Word handshake into the playback unit: a transfer happens when wordValid and wordReady are both high.
// The master offers the word; the slave owns wordReady, which never depends on wordValid.
interface playback_unit_if import ch_unit_pkg::*; #(
  parameter int WORD_W = WORD_W_DEFAULT
);

  logic [WORD_W-1:0] wordIn;
  logic              wordValid;
  logic              wordReady;

  modport master (output wordIn, output wordValid, input wordReady);
  modport slave  (input wordIn, input wordValid, output wordReady);

endinterface

// File: rtl/playback_unit_sample_edge.sv
// Rising-edge detector for a level synchronous to clk; the pulse is combinational off a registered history bit.
// A level held high for many cycles yields a single one-cycle pulse.
module sample_edge (
  input  logic clk,
  input  logic resetN,
  input  logic levelIn,
  output logic pulseOut
);

  logic levelQ;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      levelQ <= 1'b0;
    end else begin
      levelQ <= levelIn;
    end
  end

  assign pulseOut = levelIn & ~levelQ;

endmodule

// File: rtl/playback_unit.sv
// Serialises words LSB first, one bit per enabled samplePulse edge, behind a one-entry holding register.
// A word accepted while idle drives bit0 two cycles after transfer; wordReady stays low while the holding register is full.
module playback_unit import ch_unit_pkg::*; #(
  parameter int   WORD_W     = WORD_W_DEFAULT,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 samplePulse,
  playback_unit_if.slave       wordBus,
  output logic                 dOut,
  output logic                 busy,
  output logic                 wordDone,
  output logic                 underrun,
  output logic [BIT_IDX_W-1:0] bitIndex
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(WORD_W - 1);

  chState_t          state;
  logic [WORD_W-1:0] shiftReg;
  logic [WORD_W-1:0] holdReg;
  logic              holdFull;
  logic              pulseEdge;
  logic              tick;
  logic              transfer;

  sample_edge uEdge (
    .clk      (clk),
    .resetN   (resetN),
    .levelIn  (samplePulse),
    .pulseOut (pulseEdge)
  );

  // The edge history keeps tracking while disabled, so edges missed under enable=0 are dropped, not replayed.
  assign tick              = enable & pulseEdge;
  assign transfer          = wordBus.wordValid & ~holdFull;
  assign wordBus.wordReady = ~holdFull;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= IDLE;
      shiftReg <= '0;
      holdReg  <= '0;
      holdFull <= 1'b0;
      bitIndex <= '0;
      busy     <= 1'b0;
      wordDone <= 1'b0;
      underrun <= 1'b0;
      dOut     <= IDLE_LEVEL;
    end else begin
      wordDone <= 1'b0;
      underrun <= 1'b0;

      // A transfer needs holdFull low and both clears below need it high, so the writes never collide.
      if (transfer) begin
        holdReg  <= wordBus.wordIn;
        holdFull <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enable && holdFull) begin
            shiftReg <= holdReg;
            holdFull <= 1'b0;
            bitIndex <= '0;
            dOut     <= holdReg[0];
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bitIndex != LAST_IDX) begin
              shiftReg <= shiftReg >> 1;
              bitIndex <= bitIndex + BIT_IDX_W'(1);
              dOut     <= shiftReg[1];
            end else begin
              wordDone <= 1'b1;
              if (holdFull) begin
                // Back-to-back words: next bit0 follows the last bit with no idle gap.
                shiftReg <= holdReg;
                holdFull <= 1'b0;
                bitIndex <= '0;
                dOut     <= holdReg[0];
              end else begin
                underrun <= 1'b1;
                busy     <= 1'b0;
                dOut     <= IDLE_LEVEL;
                state    <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_playback_unit.sv
// Scoreboarded bench for playback_unit: stimulus queues expected serial bits and word-end events,
// a negedge monitor checks dOut at every bit tick and underrun at every wordDone.
module tb_playback_unit;

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable;
  logic       samplePulse;
  logic       dOut0, busy0, wordDone0, underrun0;
  logic [5:0] bitIndex0;
  logic       dOut1, busy1, wordDone1, underrun1;
  logic [5:0] bitIndex1;

  int   nChecks  = 0;
  int   nFails   = 0;
  int   doneCnt  = 0;
  int   underCnt = 0;
  int   done1Cnt = 0;
  logic prevS    = 1'b0;
  logic bitQ[$];
  logic evQ[$];

  playback_unit_if #(.WORD_W(32)) pif0 ();
  playback_unit_if #(.WORD_W(32)) pif1 ();

  playback_unit #(.WORD_W(32), .IDLE_LEVEL(1'b0)) dut0 (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .samplePulse (samplePulse),
    .wordBus     (pif0),
    .dOut        (dOut0),
    .busy        (busy0),
    .wordDone    (wordDone0),
    .underrun    (underrun0),
    .bitIndex    (bitIndex0)
  );

  playback_unit #(.WORD_W(32), .IDLE_LEVEL(1'b1)) dut1 (
    .clk         (clk),
    .resetN      (resetN),
    .enable      (enable),
    .samplePulse (samplePulse),
    .wordBus     (pif1),
    .dOut        (dOut1),
    .busy        (busy1),
    .wordDone    (wordDone1),
    .underrun    (underrun1),
    .bitIndex    (bitIndex1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prevS <= resetN ? samplePulse : 1'b0;

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doTick();
    samplePulse = 1'b1;
    stepCycle();
    samplePulse = 1'b0;
    stepCycle();
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxWait, output int waited);
    waited = 0;
    pif0.wordIn    = w;
    pif0.wordValid = 1'b1;
    while (!pif0.wordReady && waited < maxWait) begin
      stepCycle();
      waited++;
    end
    checkBit("wordReadyBeforeTimeout", pif0.wordReady, 1'b1);
    stepCycle();
    pif0.wordValid = 1'b0;
    checkBit("holdFullAfterTransfer", pif0.wordReady, 1'b0);
    for (int i = 0; i < 32; i++) bitQ.push_back(w[i]);
  endtask

  // Monitor: a tick is due at the next rising edge, so the bit on dOut now is the one being completed.
  always @(negedge clk) begin
    logic expBit;
    logic expUnder;
    if (resetN && busy0 && enable && samplePulse && !prevS) begin
      if (bitQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL serialBit: DUT shifting dOut=%b, expected no bit pending", dOut0);
      end else begin
        expBit = bitQ.pop_front();
        checkBit("serialBit", dOut0, expBit);
      end
    end
    if (wordDone0) begin
      doneCnt++;
      if (evQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL wordDoneEvent: got wordDone=1, expected no word end");
      end else begin
        expUnder = evQ.pop_front();
        checkBit("underrunAtWordEnd", underrun0, expUnder);
      end
    end
    if (underrun0) begin
      underCnt++;
      checkBit("underrunWithDone", wordDone0, 1'b1);
    end
    if (wordDone1) done1Cnt++;
  end

  initial begin
    int waited;
    int d0;
    int u0;
    resetN         = 1'b0;
    enable         = 1'b1;
    samplePulse    = 1'b0;
    pif0.wordIn    = '0;
    pif0.wordValid = 1'b0;
    pif1.wordIn    = '0;
    pif1.wordValid = 1'b0;
    repeat (3) stepCycle();

    checkBit("rstBusy", busy0, 1'b0);
    checkVal("rstBitIndex", int'(bitIndex0), 0);
    checkBit("rstWordReady", pif0.wordReady, 1'b1);
    checkBit("rstDout", dOut0, 1'b0);
    checkBit("rstWordDone", wordDone0, 1'b0);
    checkBit("rstUnderrun", underrun0, 1'b0);
    checkBit("rstDoutIdleHigh", dOut1, 1'b1);
    checkBit("rstWordReady1", pif1.wordReady, 1'b1);
    resetN = 1'b1;
    stepCycle();

    // Single word from idle, then underrun.
    sendWord(32'hA5A5_0001, 10, waited);
    checkBit("latN1Busy", busy0, 1'b0);
    checkBit("latN1Dout", dOut0, 1'b0);
    stepCycle();
    checkBit("latN2Busy", busy0, 1'b1);
    checkBit("latN2Bit0", dOut0, 1'b1);
    checkBit("latN2Ready", pif0.wordReady, 1'b1);
    checkVal("latN2Index", int'(bitIndex0), 0);
    evQ.push_back(1'b1);
    d0 = doneCnt;
    u0 = underCnt;
    repeat (31) doTick();
    checkVal("noDoneBeforeTick32", doneCnt, d0);
    checkVal("index31", int'(bitIndex0), 31);
    doTick();
    checkVal("doneAtTick32", doneCnt, d0 + 1);
    checkVal("underrunAtTick32", underCnt, u0 + 1);
    checkBit("busyFalls", busy0, 1'b0);
    checkBit("idleDout", dOut0, 1'b0);

    // Back-to-back words: no gap, one wordDone, no underrun at the join.
    sendWord(32'hFFFF_FFFF, 10, waited);
    sendWord(32'h0000_0000, 10, waited);
    checkVal("queuedWait", waited, 1);
    evQ.push_back(1'b0);
    evQ.push_back(1'b1);
    d0 = doneCnt;
    u0 = underCnt;
    repeat (31) doTick();
    samplePulse = 1'b1;
    stepCycle();
    checkBit("b2bBusy", busy0, 1'b1);
    checkBit("b2bZeroStarts", dOut0, 1'b0);
    checkBit("b2bWordDone", wordDone0, 1'b1);
    checkBit("b2bNoUnderrun", underrun0, 1'b0);
    checkVal("b2bIndex", int'(bitIndex0), 0);
    samplePulse = 1'b0;
    stepCycle();
    checkVal("b2bOneDone", doneCnt, d0 + 1);
    checkVal("b2bUnderCnt", underCnt, u0);
    repeat (32) doTick();
    checkVal("b2bFinalUnder", underCnt, u0 + 1);

    // wordValid held while the holding register is full.
    sendWord(32'hCAFE_0F0F, 10, waited);
    sendWord(32'h0F0F_00FF, 10, waited);
    evQ.push_back(1'b0);
    evQ.push_back(1'b0);
    evQ.push_back(1'b1);
    fork
      begin
        sendWord(32'h1234_5678, 300, waited);
      end
      begin
        repeat (96) doTick();
      end
    join
    checkBit("heldValidWaited", waited > 32, 1'b1);
    checkBit("heldValidIdle", busy0, 1'b0);

    // Long strobe and enable freeze.
    sendWord(32'h8421_F01D, 10, waited);
    evQ.push_back(1'b1);
    stepCycle();
    repeat (3) doTick();
    checkVal("indexBeforeLong", int'(bitIndex0), 3);
    samplePulse = 1'b1;
    repeat (10) stepCycle();
    samplePulse = 1'b0;
    stepCycle();
    checkVal("longStrobeOneTick", int'(bitIndex0), 4);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      doTick();
      checkVal("frozenIndex", int'(bitIndex0), 4);
      checkBit("frozenDout", dOut0, 1'b1);
    end
    enable = 1'b1;
    doTick();
    checkVal("noReplay", int'(bitIndex0), 5);
    repeat (27) doTick();
    checkBit("enableTestIdle", busy0, 1'b0);

    // Reset mid-word discards the partial word.
    sendWord(32'h0F0F_3C3C, 10, waited);
    stepCycle();
    checkBit("bit0Zero", dOut0, 1'b0);
    repeat (17) doTick();
    checkVal("midIndex", int'(bitIndex0), 17);
    checkBit("bit17", dOut0, 1'b1);
    checkVal("pendingEvents", evQ.size(), 0);
    resetN = 1'b0;
    stepCycle();
    checkBit("midRstBusy", busy0, 1'b0);
    checkVal("midRstIndex", int'(bitIndex0), 0);
    checkBit("midRstReady", pif0.wordReady, 1'b1);
    checkBit("midRstDout", dOut0, 1'b0);
    checkVal("discardedBits", bitQ.size(), 15);
    bitQ.delete();
    resetN = 1'b1;
    stepCycle();
    sendWord(32'h0000_0003, 10, waited);
    stepCycle();
    checkBit("postRstBusy", busy0, 1'b1);
    checkBit("postRstBit0", dOut0, 1'b1);
    checkVal("postRstIndex", int'(bitIndex0), 0);
    evQ.push_back(1'b1);
    repeat (32) doTick();

    // Ticks with nothing loaded: both units stay idle.
    for (int k = 0; k < 5; k++) begin
      samplePulse = 1'b1;
      stepCycle();
      checkBit("idleLevelHigh", dOut1, 1'b1);
      checkBit("idleBusy1", busy1, 1'b0);
      checkBit("idleWordDone1", wordDone1, 1'b0);
      checkBit("idleDout0", dOut0, 1'b0);
      checkBit("idleBusy0", busy0, 1'b0);
      samplePulse = 1'b0;
      stepCycle();
    end

    checkVal("leftoverBits", bitQ.size(), 0);
    checkVal("leftoverEvents", evQ.size(), 0);
    checkVal("dut1Done", done1Cnt, 0);
    checkVal("dut1Index", int'(bitIndex1), 0);
    checkBit("dut1Underrun", underrun1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at t=%0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
